bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Reads the packed 8-digit BCD time word and PM flag produced by the alarm and clock time blocks. Drives a multiplexed 8-digit common-anode seven-segment display.
- Time-multiplexes the digits with a per-digit prescaler and blanks each slot briefly to prevent ghosting.
- Snapshots the input once per frame so no frame shows a torn value. Supports per-digit blinking for time-set mode and suppresses a leading-zero hours digit.

Parameters:
- DIGIT_PERIOD, 5000: clock cycles per digit slot (1 kHz slot rate, 125 Hz frame rate at 5 MHz).
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must satisfy 0 < BLANK_CYCLES < DIGIT_PERIOD.
- BLINK_PERIOD, 2500000: cycles per blink phase (0.5 s).

Ports:
- i_Clk_5MHz  in  1  system clock.
- i_Reset  in  1  synchronous active-high reset.
- i_Time  in  32  packed BCD {H1,H2,M1,M2,S1,S2,F1,F2}; F2 = [3:0], H1 = [31:28].
- i_PM  in  1  PM indicator.
- i_Blink_Mask  in  8  bit k=1 blinks digit k (digit 0 = F2, digit 7 = H1).
- i_Enable  in  1  0 = display dark; counters keep running.
- o_Anodes  out  8  active-low digit enables, bit k = digit k.
- o_Segments  out  7  active-low segments {g,f,e,d,c,b,a}.
- o_DP  out  1  active-low decimal point.

Behaviour:
- Reset (synchronous, i_Reset=1 at a clock edge) sets:
  - prescaler = 0, digit index = 0;
  - blink counter = 0, blink phase = 0 (visible);
  - snapshot time, PM and mask = 0;
  - o_Anodes = 8'hFF, o_Segments = 7'h7F, o_DP = 1.
- Reset mid-slot or mid-frame takes effect on the next edge; there is no partial-frame carry-over.
- Prescaler counts 0..DIGIT_PERIOD-1. At DIGIT_PERIOD-1 it wraps to 0 and the digit index increments modulo 8 (7 -> 0).
- Snapshot: time, PM and mask load from the inputs on every cycle where index==0 and prescaler==0. This includes the first cycle after reset deasserts. No other cycle updates the snapshot.
- Blink counter counts 0..BLINK_PERIOD-1; blink phase toggles at the wrap.
- All outputs are registered. Outputs at edge t+1 are a function of the index, prescaler, phase and snapshot registers at edge t. This gives 1-cycle latency.
- Digit k is dark (o_Anodes = FF, o_Segments = 7F, o_DP = 1) when any of the following holds:
  - i_Enable = 0;
  - prescaler < BLANK_CYCLES;
  - blink phase = 1 and snapshot mask bit k = 1;
  - k = 7 and snapshot H1 = 0 (leading-zero suppression).
- Otherwise o_Anodes has only bit k low, and o_Segments shows the snapshot nibble for digit k.
- Segment decode is the standard 0-9 pattern. Nibble values 10-15 are invalid and display a dash (only g lit, o_Segments = 7'h3F).
- o_DP is low (lit) in two cases: on digit 2 (S2, seconds/fraction separator) always, and on digit 6 (H2) when snapshot PM = 1. Otherwise it is high. When the digit is dark, DP is dark too.
- Input changes mid-frame are invisible until the next slot-0 start.
- i_Enable is sampled live, not snapshotted.
- Simultaneous events: a snapshot load and a blink toggle on the same cycle are independent; both take effect.

Decomposition:
- Shared package holds:
  - segment pattern constants (digits 0-9, dash, blank);
  - digit index constants (DIGIT_F2=0 ... DIGIT_H1=7);
  - the DP positions (separator = 2, PM = 6).
- One combinational sub-module, bcd_to_seg: 4-bit nibble in, 7-bit active-low pattern out, dash for values above 9.
- The scanner instantiates bcd_to_seg once on the muxed snapshot nibble.

Test Plan (DIGIT_PERIOD=8, BLANK_CYCLES=2, BLINK_PERIOD=64):
- Reset sequencing:
  - Stimulus: reset, then i_Time=32'h12345678, mask=0, i_Enable=1.
  - Required: slot 0 cycles 0-2 show anodes FF. From the output registered after prescaler=2 (cycle 3), anodes=FE and segments=pattern(8)=7'h00. Frame order is 8,7,6,5,4,3,2,1 on digits 0..7, and the DP is lit only on digit 2.
- Snapshot tear-free:
  - Stimulus: change i_Time to 32'h11111111 while index=3.
  - Required: digits 4-7 still show 4,3,2,1. The new value appears from the next slot 0.
- Leading zero, PM and invalid nibble:
  - Stimulus: i_Time=32'h0930_00_00 (H1=0), i_PM=1.
  - Required: digit 7 is dark for its whole slot, and the digit 6 slot has o_DP=0.
  - Stimulus: nibble F on digit 1.
  - Required: o_Segments=7'h3F.
- Blink:
  - Stimulus: mask=8'hC0.
  - Required: digits 6 and 7 are lit for 64 cycles and dark for 64 cycles. Other digits are unaffected.
- Enable and mid-operation reset:
  - Stimulus: i_Enable=0.
  - Required: anodes FF on the next output cycle while the index keeps advancing.
  - Stimulus: assert i_Reset at index=5, prescaler=4.
  - Required: next cycle outputs are at reset values, the index restarts at 0, and the snapshot reloads on the first cycle after release.

Source files
------------

// File: rtl/bcd_display_scanner_pkg.sv
// bcd_display_scanner_pkg: segment patterns, digit positions and DP positions for the display scanner
package bcd_display_scanner_pkg;
  localparam logic [6:0] SEG_DIGIT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] ANODES_OFF = 8'hFF;
  localparam logic [2:0] DIGIT_F2 = 3'd0;
  localparam logic [2:0] DIGIT_F1 = 3'd1;
  localparam logic [2:0] DIGIT_S2 = 3'd2;
  localparam logic [2:0] DIGIT_S1 = 3'd3;
  localparam logic [2:0] DIGIT_M2 = 3'd4;
  localparam logic [2:0] DIGIT_M1 = 3'd5;
  localparam logic [2:0] DIGIT_H2 = 3'd6;
  localparam logic [2:0] DIGIT_H1 = 3'd7;
  localparam logic [2:0] DP_SEP = DIGIT_S2;
  localparam logic [2:0] DP_PM = DIGIT_H2;
endpackage

// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: time/control inputs and multiplexed display outputs of the scanner
interface bcd_display_scanner_if;
  logic [31:0] i_Time;
  logic i_PM;
  logic [7:0] i_Blink_Mask;
  logic i_Enable;
  logic [7:0] o_Anodes;
  logic [6:0] o_Segments;
  logic o_DP;
  modport master (output i_Time, i_PM, i_Blink_Mask, i_Enable, input o_Anodes, o_Segments, o_DP);
  modport slave (input i_Time, i_PM, i_Blink_Mask, i_Enable, output o_Anodes, o_Segments, o_DP);
endinterface

// File: rtl/bcd_display_scanner_bcd_to_seg.sv
// bcd_to_seg: BCD nibble to active-low {g..a} pattern, dash for values above 9
module bcd_to_seg
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb seg = nib > 4'd9 ? SEG_DASH : SEG_DIGIT[nib];
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: 8-digit multiplexed seven-segment driver with per-frame snapshot, blink and blanking
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int DIGIT_PERIOD = 5000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_PERIOD = 2500000
) (
  input logic i_Clk_5MHz,
  input logic i_Reset,
  bcd_display_scanner_if.slave bus
);
  localparam int PW = $clog2(DIGIT_PERIOD);
  localparam int BW = BLINK_PERIOD > 1 ? $clog2(BLINK_PERIOD) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0] idx_q, idx_d;
  logic [BW-1:0] blk_q, blk_d;
  logic phase_q, phase_d;
  logic [31:0] time_q, time_d;
  logic pm_q, pm_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic [6:0] dec;
  logic load, dark, slot_end, blink_end;
  bcd_to_seg u_dec (.nib(time_q[{idx_q, 2'b00} +: 4]), .seg(dec));
  always_comb begin
    slot_end = pre_q == PW'(DIGIT_PERIOD - 1);
    blink_end = blk_q == BW'(BLINK_PERIOD - 1);
    load = idx_q == DIGIT_F2 && pre_q == '0;
    pre_d = slot_end ? '0 : pre_q + 1'b1;
    idx_d = slot_end ? idx_q + 3'd1 : idx_q;
    blk_d = blink_end ? '0 : blk_q + 1'b1;
    phase_d = blink_end ? ~phase_q : phase_q;
    time_d = load ? bus.i_Time : time_q;
    pm_d = load ? bus.i_PM : pm_q;
    mask_d = load ? bus.i_Blink_Mask : mask_q;
    // a zero tens-of-hours digit stays dark rather than showing a leading 0
    dark = !bus.i_Enable || pre_q < PW'(BLANK_CYCLES) || (phase_q && mask_q[idx_q])
           || (idx_q == DIGIT_H1 && time_q[31:28] == 4'd0);
    an_d = dark ? ANODES_OFF : ~(8'd1 << idx_q);
    seg_d = dark ? SEG_BLANK : dec;
    dp_d = dark || !(idx_q == DP_SEP || (idx_q == DP_PM && pm_q));
  end
  always_ff @(posedge i_Clk_5MHz) begin
    if (i_Reset) begin
      pre_q <= '0;
      idx_q <= '0;
      blk_q <= '0;
      phase_q <= 1'b0;
      time_q <= '0;
      pm_q <= 1'b0;
      mask_q <= '0;
      an_q <= ANODES_OFF;
      seg_q <= SEG_BLANK;
      dp_q <= 1'b1;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      blk_q <= blk_d;
      phase_q <= phase_d;
      time_q <= time_d;
      pm_q <= pm_d;
      mask_q <= mask_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign bus.o_Anodes = an_q;
  assign bus.o_Segments = seg_q;
  assign bus.o_DP = dp_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed and randomized checks against a cycle-count based display model
module tb_bcd_display_scanner;
  localparam int DP = 8, BL = 2, BP = 64, FR = 8 * DP;
  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
                                      7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bcd_display_scanner_if bus ();
  bcd_display_scanner #(.DIGIT_PERIOD(DP), .BLANK_CYCLES(BL), .BLINK_PERIOD(BP)) dut (
    .i_Clk_5MHz(clk), .i_Reset(rst), .bus(bus)
  );
  int n_cmp = 0, n_fail = 0;
  int m_n, p_n, mi;
  logic [31:0] m_time;
  logic m_pm, mdark;
  logic [7:0] m_mask, e_an;
  logic [6:0] e_seg;
  logic e_dp;
  // model: n counts non-reset cycles; slot, digit and blink phase follow from n by division
  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; p_n = -1; m_time = '0; m_pm = 1'b0; m_mask = '0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      mi = (m_n / DP) % 8;
      mdark = !bus.i_Enable || (m_n % DP) < BL || (((m_n / BP) % 2) == 1 && m_mask[mi])
              || (mi == 7 && m_time[31:28] == 4'd0);
      e_an = mdark ? 8'hFF : ~(8'd1 << mi);
      e_seg = mdark ? 7'h7F : PAT[m_time[mi*4 +: 4]];
      e_dp = mdark || !(mi == 2 || (mi == 6 && m_pm));
      if (m_n % FR == 0) begin
        m_time = bus.i_Time; m_pm = bus.i_PM; m_mask = bus.i_Blink_Mask;
      end
      p_n = m_n;
      m_n++;
    end
  end
  task automatic test_reset();
    int n, idx;
    logic lit;
    logic [7:0] ea;
    logic [6:0] es;
    logic ed;
    rst = 1; bus.i_Time = '0; bus.i_PM = 0; bus.i_Blink_Mask = '0; bus.i_Enable = 1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.o_Anodes !== 8'hFF) begin n_fail++; $display("FAIL reset_anodes: got %h want ff", bus.o_Anodes); end
    n_cmp++; if (bus.o_Segments !== 7'h7F) begin n_fail++; $display("FAIL reset_segments: got %h want 7f", bus.o_Segments); end
    n_cmp++; if (bus.o_DP !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", bus.o_DP); end
    bus.i_Time = 32'h12345678;
    rst = 0;
    for (int j = 1; j <= FR; j++) begin
      @(negedge clk);
      n = j - 1; idx = n / DP; lit = (n % DP) >= BL;
      ea = lit ? ~(8'd1 << idx) : 8'hFF;
      es = lit ? PAT[8 - idx] : 7'h7F;
      ed = !(lit && idx == 2);
      n_cmp++;
      if ({bus.o_Anodes, bus.o_Segments, bus.o_DP} !== {ea, es, ed}) begin
        n_fail++; $display("FAIL reset_frame c%0d: got %h/%h/%b want %h/%h/%b", j, bus.o_Anodes, bus.o_Segments, bus.o_DP, ea, es, ed);
      end
    end
  endtask
  task automatic test_snapshot_tear();
    int f0;
    for (int k = 0; k < 2 * FR && (m_n % FR) != 3 * DP; k++) @(negedge clk);
    n_cmp++; if ((m_n % FR) != 3 * DP) begin n_fail++; $display("FAIL tear_wait: got %0d want %0d", m_n % FR, 3 * DP); end
    bus.i_Time = 32'h11111111;
    f0 = m_n / FR;
    repeat (2 * FR) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_Anodes, bus.o_Segments, bus.o_DP} !== {e_an, e_seg, e_dp}) begin
        n_fail++; $display("FAIL tear_model n%0d: got %h/%h/%b want %h/%h/%b", p_n, bus.o_Anodes, bus.o_Segments, bus.o_DP, e_an, e_seg, e_dp);
      end
      if (p_n % FR == 4 * DP + 4) begin
        n_cmp++;
        if (p_n / FR == f0 && {bus.o_Anodes, bus.o_Segments} !== {8'hEF, 7'h19}) begin
          n_fail++; $display("FAIL tear_old_digit4: got %h/%h want ef/19", bus.o_Anodes, bus.o_Segments);
        end
        if (p_n / FR > f0 && {bus.o_Anodes, bus.o_Segments} !== {8'hEF, 7'h79}) begin
          n_fail++; $display("FAIL tear_new_digit4: got %h/%h want ef/79", bus.o_Anodes, bus.o_Segments);
        end
      end
    end
  endtask
  task automatic test_lz_pm_invalid();
    int f0, idx;
    bus.i_Time = 32'h093000F0; bus.i_PM = 1;
    f0 = m_n / FR;
    repeat (3 * FR) begin
      @(negedge clk);
      idx = (p_n / DP) % 8;
      n_cmp++;
      if ({bus.o_Anodes, bus.o_Segments, bus.o_DP} !== {e_an, e_seg, e_dp}) begin
        n_fail++; $display("FAIL lz_model n%0d: got %h/%h/%b want %h/%h/%b", p_n, bus.o_Anodes, bus.o_Segments, bus.o_DP, e_an, e_seg, e_dp);
      end
      if (p_n / FR == f0 + 1) begin
        if (idx == 7) begin
          n_cmp++; if (bus.o_Anodes !== 8'hFF) begin n_fail++; $display("FAIL lz_h1_dark: got %h want ff", bus.o_Anodes); end
        end
        if (idx == 6 && p_n % DP >= BL) begin
          n_cmp++; if (bus.o_DP !== 1'b0) begin n_fail++; $display("FAIL pm_dp: got %b want 0", bus.o_DP); end
        end
        if (idx == 1 && p_n % DP >= BL) begin
          n_cmp++; if (bus.o_Segments !== 7'h3F) begin n_fail++; $display("FAIL dash: got %h want 3f", bus.o_Segments); end
        end
      end
    end
  endtask
  task automatic test_blink();
    int f0, idx;
    logic [7:0] ea;
    bus.i_Time = 32'h12345678; bus.i_PM = 0; bus.i_Blink_Mask = 8'hC0;
    f0 = m_n / FR;
    repeat (4 * BP) begin
      @(negedge clk);
      idx = (p_n / DP) % 8;
      n_cmp++;
      if ({bus.o_Anodes, bus.o_Segments, bus.o_DP} !== {e_an, e_seg, e_dp}) begin
        n_fail++; $display("FAIL blink_model n%0d: got %h/%h/%b want %h/%h/%b", p_n, bus.o_Anodes, bus.o_Segments, bus.o_DP, e_an, e_seg, e_dp);
      end
      if (p_n / FR > f0 && p_n % DP >= BL) begin
        ea = (idx >= 6 && (p_n / BP) % 2 == 1) ? 8'hFF : ~(8'd1 << idx);
        n_cmp++;
        if (bus.o_Anodes !== ea) begin n_fail++; $display("FAIL blink_anodes n%0d: got %h want %h", p_n, bus.o_Anodes, ea); end
      end
    end
  endtask
  task automatic test_enable();
    bus.i_Blink_Mask = '0;
    for (int k = 0; k < 2 * DP && (m_n % DP) != 4; k++) @(negedge clk);
    bus.i_Enable = 0;
    @(negedge clk);
    n_cmp++; if (bus.o_Anodes !== 8'hFF) begin n_fail++; $display("FAIL enable_off: got %h want ff", bus.o_Anodes); end
    repeat (3 * DP) @(negedge clk);
    bus.i_Enable = 1;
    repeat (2 * FR) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_Anodes, bus.o_Segments, bus.o_DP} !== {e_an, e_seg, e_dp}) begin
        n_fail++; $display("FAIL enable_model n%0d: got %h/%h/%b want %h/%h/%b", p_n, bus.o_Anodes, bus.o_Segments, bus.o_DP, e_an, e_seg, e_dp);
      end
    end
  endtask
  task automatic test_mid_reset();
    for (int k = 0; k < 2 * FR && (m_n % FR) != 5 * DP + 4; k++) @(negedge clk);
    n_cmp++; if ((m_n % FR) != 5 * DP + 4) begin n_fail++; $display("FAIL midrst_wait: got %0d want %0d", m_n % FR, 5 * DP + 4); end
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if ({bus.o_Anodes, bus.o_Segments, bus.o_DP} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_fail++; $display("FAIL midrst_outputs: got %h/%h/%b want ff/7f/1", bus.o_Anodes, bus.o_Segments, bus.o_DP);
    end
    bus.i_Time = 32'h87654321;
    rst = 0;
    for (int j = 1; j <= FR; j++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_Anodes, bus.o_Segments, bus.o_DP} !== {e_an, e_seg, e_dp}) begin
        n_fail++; $display("FAIL midrst_model n%0d: got %h/%h/%b want %h/%h/%b", p_n, bus.o_Anodes, bus.o_Segments, bus.o_DP, e_an, e_seg, e_dp);
      end
      if (j == 3) begin
        n_cmp++;
        if ({bus.o_Anodes, bus.o_Segments} !== {8'hFE, 7'h79}) begin
          n_fail++; $display("FAIL midrst_restart: got %h/%h want fe/79", bus.o_Anodes, bus.o_Segments);
        end
      end
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      bus.i_Time = $urandom; bus.i_PM = 1'($urandom); bus.i_Blink_Mask = 8'($urandom);
      bus.i_Enable = $urandom_range(0, 4) != 0;
      rst = $urandom_range(0, 9) == 0;
      repeat ($urandom_range(1, 3 * FR)) begin
        @(negedge clk);
        rst = 0;
        n_cmp++;
        if ({bus.o_Anodes, bus.o_Segments, bus.o_DP} !== {e_an, e_seg, e_dp}) begin
          n_fail++; $display("FAIL random_model n%0d: got %h/%h/%b want %h/%h/%b", p_n, bus.o_Anodes, bus.o_Segments, bus.o_DP, e_an, e_seg, e_dp);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_snapshot_tear();
    test_lz_pm_invalid();
    test_blink();
    test_enable();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
